// File: rtl/apb_int_ctrl_pkg.sv
// Shared register offsets (word index from PADDR[5:2]) and request FSM state type
// for the APB interrupt aggregator.
package apb_int_ctrl_pkg;

  localparam logic [3:0] REG_MASK    = 4'h0;
  localparam logic [3:0] REG_PENDING = 4'h1;
  localparam logic [3:0] REG_SET     = 4'h2;
  localparam logic [3:0] REG_EDGE    = 4'h3;
  localparam logic [3:0] REG_STATUS  = 4'h4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/apb_int_ctrl_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module int_prio_enc #(
  parameter int unsigned N_IRQ = 32,
  parameter int unsigned ID_W  = 5
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan downwards so the last hit is the lowest index.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/apb_int_ctrl.sv
// APB-configured interrupt aggregator: per-source pending bits, mask, edge/level
// capture and a req/ack handshake presenting the lowest-index active source.
module apb_int_ctrl
  import apb_int_ctrl_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned N_IRQ          = 32,
  parameter int unsigned ID_W           = 5
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [N_IRQ-1:0]          irq_src_i,
  output logic                      irq_req_o,
  output logic [ID_W-1:0]           irq_id_o,
  input  logic                      irq_ack_i
);

  localparam logic [N_IRQ-1:0] ONE = 1;

  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] src_prev_q;
  logic [ID_W-1:0]  id_q, id_d;
  state_e           state_q, state_d;

  logic [3:0]       reg_addr;
  logic             apb_wr;
  logic [N_IRQ-1:0] hw_event, sw_set, sw_clr, ack_clr, active;
  logic             win_valid;
  logic [ID_W-1:0]  win_id;
  logic             unused_bits;

  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign reg_addr    = PADDR[5:2];
  assign apb_wr      = PSEL & PENABLE & PWRITE;
  assign unused_bits = ^{PADDR, PWDATA};

  // Edge-mode bits only see the rising transition; level-mode bits see the raw line.
  assign hw_event = irq_src_i & ~(edge_q & src_prev_q);
  assign sw_set   = (apb_wr && reg_addr == REG_SET)     ? PWDATA[N_IRQ-1:0] : '0;
  assign sw_clr   = (apb_wr && reg_addr == REG_PENDING) ? PWDATA[N_IRQ-1:0] : '0;
  assign ack_clr  = (state_q == REQ && irq_ack_i) ? (ONE << id_q) : '0;
  assign active   = pend_q & mask_q;

  // Sets are OR-ed in after clearing so a same-cycle set always wins.
  assign pend_d = (pend_q & ~(sw_clr | ack_clr)) | hw_event | sw_set;

  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (apb_wr && reg_addr == REG_MASK) mask_d = PWDATA[N_IRQ-1:0];
    if (apb_wr && reg_addr == REG_EDGE) edge_d = PWDATA[N_IRQ-1:0];
  end

  int_prio_enc #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (active),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = REQ;
          id_d    = win_id;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d = GAP;
        end else if (!pend_q[id_q] || !mask_q[id_q]) begin
          state_d = IDLE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_q     <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      src_prev_q <= '0;
      id_q       <= '0;
      state_q    <= IDLE;
    end else begin
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      src_prev_q <= irq_src_i;
      id_q       <= id_d;
      state_q    <= state_d;
    end
  end

  // Request is decoded straight from the state so reset removes it immediately.
  assign irq_req_o = (state_q == REQ);
  assign irq_id_o  = id_q;

  always_comb begin
    PRDATA = '0;
    case (reg_addr)
      REG_MASK:    PRDATA = 32'(mask_q);
      REG_PENDING: PRDATA = 32'(pend_q);
      REG_EDGE:    PRDATA = 32'(edge_q);
      REG_STATUS:  PRDATA = {irq_req_o, 26'b0, 5'(id_q)};
      default:     PRDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_apb_int_ctrl.sv
// Self-checking bench for apb_int_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_apb_int_ctrl;

  localparam int N = 32;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [11:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [N-1:0] irq_src_i = '0;
  logic        irq_req_o;
  logic [4:0]  irq_id_o;
  logic        irq_ack_i = 1'b0;

  apb_int_ctrl dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .irq_src_i (irq_src_i),
    .irq_req_o (irq_req_o),
    .irq_id_o  (irq_id_o),
    .irq_ack_i (irq_ack_i)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Stimulus for the next cycle
  logic [31:0] src_v = '0;
  logic        ack_v = 1'b0;
  logic        wr_v = 1'b0;
  logic        rd_v = 1'b0;
  logic [3:0]  addr_v = '0;
  logic [31:0] wdata_v = '0;

  // Behavioural model
  logic [31:0] m_mask, m_edge, m_pend, m_prev;
  logic        m_req, m_gap;
  int          m_id;

  task automatic model_reset();
    m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0;
    m_req = 1'b0; m_gap = 1'b0; m_id = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:    return m_mask;
      4'd1:    return m_pend;
      4'd3:    return m_edge;
      4'd4:    return {m_req, 26'b0, 5'(m_id)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] ev, setb, clrb, ackb, act;
    ev   = '0;
    for (int i = 0; i < N; i++)
      ev[i] = m_edge[i] ? (src_v[i] && !m_prev[i]) : src_v[i];
    setb = (wr_v && addr_v == 4'd2) ? wdata_v : '0;
    clrb = (wr_v && addr_v == 4'd1) ? wdata_v : '0;
    ackb = (m_req && ack_v) ? (32'h1 << m_id) : '0;
    act  = m_pend & m_mask;
    if (m_req) begin
      if (ack_v) begin
        m_req = 1'b0;
        m_gap = 1'b1;
      end else if (!m_pend[m_id] || !m_mask[m_id]) begin
        m_req = 1'b0;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (act != 0) begin
      for (int i = N - 1; i >= 0; i--) if (act[i]) m_id = i;
      m_req = 1'b1;
    end
    m_pend = (m_pend & ~(clrb | ackb)) | ev | setb;
    if (wr_v && addr_v == 4'd0) m_mask = wdata_v;
    if (wr_v && addr_v == 4'd3) m_edge = wdata_v;
    m_prev = src_v;
  endtask

  // One clock: drive, optionally check read data, clock, then check outputs.
  task automatic cycle(input string tag);
    irq_src_i = src_v;
    irq_ack_i = ack_v;
    PSEL      = wr_v | rd_v;
    PENABLE   = wr_v | rd_v;
    PWRITE    = wr_v;
    PADDR     = {6'b0, addr_v, 2'b00};
    PWDATA    = wdata_v;
    #1;
    if (rd_v) check_eq({tag, "/prdata"}, PRDATA, model_read(addr_v));
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
    check_eq({tag, "/req"}, {31'b0, irq_req_o}, {31'b0, m_req});
    check_eq({tag, "/id"}, {27'b0, irq_id_o}, 32'(m_id));
    ack_v = 1'b0; wr_v = 1'b0; rd_v = 1'b0; addr_v = '0;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    wr_v = 1'b1; addr_v = a; wdata_v = d;
    cycle("wr");
  endtask

  task automatic apb_read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_v = 1'b1; addr_v = a;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = {6'b0, a, 2'b00};
    #1;
    check_eq(tag, PRDATA, exp);
    cycle(tag);
  endtask

  int acks;

  initial begin
    model_reset();
    repeat (2) @(negedge HCLK);
    check_eq("rst_req", {31'b0, irq_req_o}, 32'h0);
    HRESETn = 1'b1;

    // Reset values
    apb_read_chk("rst_mask", 4'd0, 32'h0);
    apb_read_chk("rst_pend", 4'd1, 32'h0);
    apb_read_chk("rst_edge", 4'd3, 32'h0);
    apb_read_chk("rst_stat", 4'd4, 32'h0);

    // Single level pulse on source 0
    apb_write(4'd0, 32'h1);
    apb_write(4'd3, 32'h0);
    src_v = 32'h1;
    cycle("t2_pulse");
    check_eq("t2_noreq_yet", {31'b0, irq_req_o}, 32'h0);
    src_v = 32'h0;
    apb_read_chk("t2_pend1", 4'd1, 32'h1);
    check_eq("t2_req", {31'b0, irq_req_o}, 32'h1);
    check_eq("t2_id", {27'b0, irq_id_o}, 32'h0);
    apb_read_chk("t2_stat", 4'd4, 32'h8000_0000);
    ack_v = 1'b1;
    cycle("t2_ack");
    check_eq("t2_gap_req", {31'b0, irq_req_o}, 32'h0);
    apb_read_chk("t2_pend0", 4'd1, 32'h0);
    repeat (3) cycle("t2_idle");
    check_eq("t2_no_rereq", {31'b0, irq_req_o}, 32'h0);

    // Software set of two sources, priority and re-request spacing
    apb_write(4'd0, 32'hFFFF_FFFF);
    apb_write(4'd2, 32'h0000_0014);
    cycle("t3_arb");
    check_eq("t3_id2", {27'b0, irq_id_o}, 32'd2);
    check_eq("t3_req2", {31'b0, irq_req_o}, 32'h1);
    apb_read_chk("t3_set_rd0", 4'd2, 32'h0);
    ack_v = 1'b1;
    cycle("t3_ack2");
    check_eq("t3_gap", {31'b0, irq_req_o}, 32'h0);
    cycle("t3_idle");
    check_eq("t3_idle_req", {31'b0, irq_req_o}, 32'h0);
    cycle("t3_rereq");
    check_eq("t3_req4", {31'b0, irq_req_o}, 32'h1);
    check_eq("t3_id4", {27'b0, irq_id_o}, 32'd4);
    apb_read_chk("t3_stat4", 4'd4, 32'h8000_0004);
    ack_v = 1'b1;
    cycle("t3_ack4");
    repeat (2) cycle("t3_drain");

    // Edge-mode source held high yields a single request
    apb_write(4'd3, 32'h8);
    apb_write(4'd0, 32'h8);
    acks = 0;
    src_v = 32'h8;
    for (int k = 0; k < 10; k++) begin
      ack_v = irq_req_o;
      if (ack_v) begin
        acks++;
        check_eq("t4_id3", {27'b0, irq_id_o}, 32'd3);
      end
      cycle("t4_hold");
    end
    check_eq("t4_one_req", 32'(acks), 32'd1);
    src_v = 32'h0;
    repeat (3) cycle("t4_after");
    check_eq("t4_no_rereq", {31'b0, irq_req_o}, 32'h0);

    // Level source re-pends after ack; then withdraw by W1C
    apb_write(4'd3, 32'h0);
    apb_write(4'd0, 32'h2);
    src_v = 32'h2;
    cycle("t5_src");
    cycle("t5_arb");
    check_eq("t5_req1", {31'b0, irq_req_o}, 32'h1);
    check_eq("t5_id1", {27'b0, irq_id_o}, 32'd1);
    ack_v = 1'b1;
    cycle("t5_ack");
    check_eq("t5_gap", {31'b0, irq_req_o}, 32'h0);
    cycle("t5_idle");
    check_eq("t5_idle_req", {31'b0, irq_req_o}, 32'h0);
    cycle("t5_rereq");
    check_eq("t5_rereq1", {31'b0, irq_req_o}, 32'h1);
    src_v = 32'h0;
    apb_write(4'd1, 32'h2);
    cycle("t5_withdraw");
    check_eq("t5_withdrawn", {31'b0, irq_req_o}, 32'h0);
    apb_read_chk("t5_pend0", 4'd1, 32'h0);

    // Asynchronous reset in the middle of a request
    apb_write(4'd0, 32'h20);
    apb_write(4'd2, 32'h20);
    cycle("t6_arb");
    check_eq("t6_req5", {31'b0, irq_req_o}, 32'h1);
    check_eq("t6_id5", {27'b0, irq_id_o}, 32'd5);
    #3 HRESETn = 1'b0;
    #1 check_eq("t6_async_drop", {31'b0, irq_req_o}, 32'h0);
    model_reset();
    @(negedge HCLK);
    HRESETn = 1'b1;
    apb_read_chk("t6_pend0", 4'd1, 32'h0);
    apb_read_chk("t6_mask0", 4'd0, 32'h0);
    repeat (2) cycle("t6_quiet");
    check_eq("t6_no_req", {31'b0, irq_req_o}, 32'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      int r;
      src_v = $urandom & $urandom & $urandom;
      ack_v = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 11);
      case (r)
        0: begin wr_v = 1'b1; addr_v = 4'd0; wdata_v = $urandom | $urandom; end
        1: begin wr_v = 1'b1; addr_v = 4'd3; wdata_v = $urandom; end
        2: begin wr_v = 1'b1; addr_v = 4'd2; wdata_v = $urandom & $urandom; end
        3: begin wr_v = 1'b1; addr_v = 4'd1; wdata_v = $urandom; end
        4: begin wr_v = 1'b1; addr_v = 4'($urandom_range(4, 15)); wdata_v = $urandom; end
        default: begin rd_v = 1'b1; addr_v = 4'($urandom_range(0, 15)); end
      endcase
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
